ram_wr_arbiter: RTL and testbench

//  Shares one RAM write-path stage (registered wr_en/data, done one cycle after wr_en) between NUM_REQ requesters.

---
 rtl/ram_arb_pkg.sv | 27 ++
 rtl/ram_wr_arbiter_rr_pick.sv | 52 +++++
 rtl/ram_wr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ram_wr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Shared types and width helpers for the RAM write-path arbiter.
//             arb_state_t  - arbiter FSM state encoding
//             timer_width  - bits needed to count 0..TIMEOUT-1
//             idx_width    - bits needed to index NUM_REQ requesters
//  Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    function automatic int timer_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin selector. Returns the first set
//             request found when searching i_ptr, i_ptr+1, ... (mod NUM_REQ).
//  Ports    : i_req  [NUM_REQ] request vector
//             i_ptr  [IDX_W]   search start position
//             o_gnt  [NUM_REQ] one-hot winner (zero when no request)
//             o_idx  [IDX_W]   winner index
//             o_vld            at least one request present
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_vld
);

    int               w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_vld = 1'b0;
        w_sum = 0;
        w_pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap the candidate position back into 0..NUM_REQ-1; the sum
            // never reaches 2*NUM_REQ so one subtraction is enough.
            w_sum = int'(i_ptr) + k;
            if (w_sum >= NUM_REQ) begin
                w_sum = w_sum - NUM_REQ;
            end
            w_pos = IDX_W'(w_sum);
            if (!o_vld && i_req[w_pos]) begin
                o_vld        = 1'b1;
                o_idx        = w_pos;
                o_gnt[w_pos] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_wr_arbiter
//  Purpose  : Shares one RAM write-path stage between NUM_REQ clients.
//             Round-robin grant, one transaction in flight, per-client
//             done/error pulses and a timeout guard on downstream done.
//  Ports    : i_clk, i_rst        clock, synchronous active-high reset
//             i_req  [NUM_REQ]    level request per client
//             i_addr/i_data       flat per-client address/data (client k at
//                                 [k*W +: W])
//             i_wr_done           completion pulse from downstream stage
//             o_wr_en             one-cycle write strobe
//             o_addr/o_data_wr    captured address/data of granted client
//             o_gnt  [NUM_REQ]    one-hot grant, ISSUE through end of WAIT
//             o_done/o_err        one-cycle success/timeout pulse to client
//             o_busy              high whenever the arbiter is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module ram_wr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SIZE_DATA = 8,
    parameter int SIZE_ADDR = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*SIZE_ADDR-1:0]   i_addr,
    input  logic [NUM_REQ*SIZE_DATA-1:0]   i_data,
    input  logic                           i_wr_done,
    output logic                           o_wr_en,
    output logic [SIZE_ADDR-1:0]           o_addr,
    output logic [SIZE_DATA-1:0]           o_data_wr,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [NUM_REQ-1:0]             o_done,
    output logic [NUM_REQ-1:0]             o_err,
    output logic                           o_busy
);

    localparam int c_IDX_W = idx_width(NUM_REQ);
    localparam int c_TMR_W = timer_width(TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_REQ - 1);

    arb_state_t            r_state, w_state_nxt;
    logic [c_IDX_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
    logic [c_IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [c_TMR_W-1:0]    r_timer, w_timer_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic [SIZE_ADDR-1:0]  r_addr, w_addr_nxt;
    logic [SIZE_DATA-1:0]  r_data, w_data_nxt;
    logic [NUM_REQ-1:0]    r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]    r_done, w_done_nxt;
    logic [NUM_REQ-1:0]    r_err, w_err_nxt;
    logic                  r_busy, w_busy_nxt;

    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [c_IDX_W-1:0]    w_pick_idx;
    logic                  w_pick_vld;
    logic [c_IDX_W-1:0]    w_ptr_adv;

    logic [SIZE_ADDR-1:0]  w_addr_arr [NUM_REQ];
    logic [SIZE_DATA-1:0]  w_data_arr [NUM_REQ];

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_addr_arr[g] = i_addr[g*SIZE_ADDR +: SIZE_ADDR];
            assign w_data_arr[g] = i_data[g*SIZE_DATA +: SIZE_DATA];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req (i_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_vld (w_pick_vld)
    );

    // Pointer moves to the client after the one just served, so a client
    // that keeps requesting is reached within NUM_REQ-1 transactions.
    assign w_ptr_adv = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_idx_nxt    = r_idx;
        w_timer_nxt  = r_timer;
        w_wr_en_nxt  = 1'b0;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_gnt_nxt    = r_gnt;
        w_done_nxt   = '0;
        w_err_nxt    = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ARB_ISSUE;
                    w_idx_nxt   = w_pick_idx;
                    w_gnt_nxt   = w_pick_gnt;
                    w_addr_nxt  = w_addr_arr[w_pick_idx];
                    w_data_nxt  = w_data_arr[w_pick_idx];
                    w_wr_en_nxt = 1'b1;
                end
            end
            ARB_ISSUE: begin
                // i_wr_done is deliberately not looked at here.
                w_timer_nxt = '0;
                w_state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (i_wr_done) begin
                    // Done takes priority over a simultaneous timeout.
                    w_done_nxt   = r_gnt;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_ptr_adv;
                    w_state_nxt  = ARB_IDLE;
                end else if (r_timer == c_TMR_LAST) begin
                    w_err_nxt    = r_gnt;
                    w_gnt_nxt    = '0;
                    w_rr_ptr_nxt = w_ptr_adv;
                    w_state_nxt  = ARB_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ARB_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= '0;
            r_idx    <= '0;
            r_timer  <= '0;
            r_wr_en  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_idx    <= w_idx_nxt;
            r_timer  <= w_timer_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_gnt    <= w_gnt_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_addr    = r_addr;
    assign o_data_wr = r_data;
    assign o_gnt     = r_gnt;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_wr_arbiter
//  Purpose  : Self-checking bench for ram_wr_arbiter. A driver issues
//             transactions and queues the expected write strobe and outcome;
//             a monitor pops and compares whenever the arbiter strobes a
//             write or pulses done/err.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int SIZE_DATA = 8;
    localparam int SIZE_ADDR = 8;
    localparam int TIMEOUT   = 16;

    localparam int c_K_WR   = 0;
    localparam int c_K_DONE = 1;
    localparam int c_K_ERR  = 2;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_REQ-1:0]           i_req;
    logic [NUM_REQ*SIZE_ADDR-1:0] i_addr;
    logic [NUM_REQ*SIZE_DATA-1:0] i_data;
    logic                         i_wr_done;
    logic                         o_wr_en;
    logic [SIZE_ADDR-1:0]         o_addr;
    logic [SIZE_DATA-1:0]         o_data_wr;
    logic [NUM_REQ-1:0]           o_gnt;
    logic [NUM_REQ-1:0]           o_done;
    logic [NUM_REQ-1:0]           o_err;
    logic                         o_busy;

    ram_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .SIZE_DATA (SIZE_DATA),
        .SIZE_ADDR (SIZE_ADDR),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .i_wr_done (i_wr_done),
        .o_wr_en   (o_wr_en),
        .o_addr    (o_addr),
        .o_data_wr (o_data_wr),
        .o_gnt     (o_gnt),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   kind;
        logic [NUM_REQ-1:0]   gnt;
        logic [SIZE_ADDR-1:0] addr;
        logic [SIZE_DATA-1:0] data;
        int                   lat;
    } exp_t;

    exp_t q_exp[$];
    exp_t e_mon;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   wr_cyc = 0;
    int   model_ptr = 0;
    logic [SIZE_ADDR-1:0] cur_addr [NUM_REQ];
    logic [SIZE_DATA-1:0] cur_data [NUM_REQ];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Round-robin reference: first requesting client at or after ptr.
    function automatic int model_pick(input logic [NUM_REQ-1:0] m, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (m[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Monitor: compares every write strobe and every done/err pulse.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (o_wr_en) begin
            chk("wr_expected", (q_exp.size() != 0) && (q_exp[0].kind == c_K_WR), 1);
            if (q_exp.size() != 0 && q_exp[0].kind == c_K_WR) begin
                e_mon = q_exp.pop_front();
                chk("gnt", o_gnt, e_mon.gnt);
                chk("addr", o_addr, e_mon.addr);
                chk("data", o_data_wr, e_mon.data);
                wr_cyc = cyc;
            end
        end
        if (|o_done || |o_err) begin
            chk("end_expected", (q_exp.size() != 0) && (q_exp[0].kind != c_K_WR), 1);
            if (q_exp.size() != 0 && q_exp[0].kind != c_K_WR) begin
                e_mon = q_exp.pop_front();
                chk("done_vec", o_done, (e_mon.kind == c_K_DONE) ? e_mon.gnt : '0);
                chk("err_vec", o_err, (e_mon.kind == c_K_ERR) ? e_mon.gnt : '0);
                chk("latency", cyc - wr_cyc, e_mon.lat);
                chk("gnt_cleared", o_gnt, 0);
                chk("busy_cleared", o_busy, 0);
            end
        end
    end

    task automatic rand_payload();
        for (int k = 0; k < NUM_REQ; k++) begin
            cur_addr[k] = SIZE_ADDR'($urandom);
            cur_data[k] = SIZE_DATA'($urandom);
        end
    endtask

    // Called at a negedge while idle. d = negedges after the strobe is seen
    // at which i_wr_done pulses (-1 = never).
    task automatic do_txn(input logic [NUM_REQ-1:0] mask, input int d, input bit drop);
        int   g;
        bit   got;
        exp_t e;
        for (int k = 0; k < NUM_REQ; k++) begin
            i_addr[k*SIZE_ADDR +: SIZE_ADDR] = cur_addr[k];
            i_data[k*SIZE_DATA +: SIZE_DATA] = cur_data[k];
        end
        i_req = mask;
        g = model_pick(mask, model_ptr);
        e.kind = c_K_WR;
        e.gnt  = NUM_REQ'(1) << g;
        e.addr = cur_addr[g];
        e.data = cur_data[g];
        e.lat  = 0;
        q_exp.push_back(e);
        if (d >= 1 && d <= TIMEOUT) begin
            e.kind = c_K_DONE;
            e.lat  = d + 1;
        end else begin
            e.kind = c_K_ERR;
            e.lat  = TIMEOUT + 1;
        end
        q_exp.push_back(e);
        model_ptr = (g + 1) % NUM_REQ;

        got = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (o_wr_en) begin
                got = 1'b1;
                break;
            end
        end
        chk("wr_en_seen", got, 1);
        if (!got) begin
            q_exp.delete();
            i_req = '0;
            return;
        end
        chk("busy_in_issue", o_busy, 1);
        if (drop) i_req[g] = 1'b0;

        got = 1'b0;
        for (int c = 0; c < TIMEOUT + 8; c++) begin
            if (!o_busy) begin
                got = 1'b1;
                break;
            end
            i_wr_done = (c == d);
            @(negedge clk);
        end
        i_wr_done = 1'b0;
        i_req     = '0;
        chk("txn_completed", got, 1);
        if (!got) q_exp.delete();
    endtask

    initial begin
        int r;
        int d;
        logic [NUM_REQ-1:0] m;
        rst       = 1'b1;
        i_req     = '0;
        i_addr    = '0;
        i_data    = '0;
        i_wr_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_wr_en", o_wr_en, 0);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_data", o_data_wr, 0);

        // All clients requesting: expect 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            do_txn(4'b1111, 2, 1'b0);
        end

        // Single request with fixed payload
        rand_payload();
        cur_addr[2] = 8'h3C;
        cur_data[2] = 8'hA5;
        do_txn(4'b0100, 2, 1'b0);
        chk("addr_holds", o_addr, 8'h3C);
        chk("data_holds", o_data_wr, 8'hA5);

        // No done ever -> timeout error
        rand_payload();
        do_txn(4'b1001, -1, 1'b0);

        // Done and timeout in the same cycle -> done wins
        rand_payload();
        do_txn(4'b0010, TIMEOUT, 1'b0);

        // Done during ISSUE is ignored -> timeout error
        rand_payload();
        do_txn(4'b0110, 0, 1'b0);

        // Requester drops its request mid-transaction
        rand_payload();
        do_txn(4'b0010, 2, 1'b1);

        // Stray done while idle
        i_wr_done = 1'b1;
        @(negedge clk);
        i_wr_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", o_busy, 0);
        chk("stray_gnt", o_gnt, 0);

        // Move pointer away from 0, then reset mid-WAIT
        rand_payload();
        do_txn(4'b0100, 1, 1'b0);
        rand_payload();
        for (int k = 0; k < NUM_REQ; k++) begin
            i_addr[k*SIZE_ADDR +: SIZE_ADDR] = cur_addr[k];
            i_data[k*SIZE_DATA +: SIZE_DATA] = cur_data[k];
        end
        i_req = 4'b1111;
        begin
            exp_t e;
            int   g;
            g = model_pick(4'b1111, model_ptr);
            e.kind = c_K_WR;
            e.gnt  = NUM_REQ'(1) << g;
            e.addr = cur_addr[g];
            e.data = cur_data[g];
            e.lat  = 0;
            q_exp.push_back(e);
        end
        repeat (3) @(negedge clk);
        chk("busy_before_rst", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_wr_en", o_wr_en, 0);
        chk("rstw_gnt", o_gnt, 0);
        chk("rstw_done", o_done, 0);
        chk("rstw_err", o_err, 0);
        chk("rstw_busy", o_busy, 0);
        chk("rstw_addr", o_addr, 0);
        rst = 1'b0;
        model_ptr = 0;
        do_txn(4'b1111, 2, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            rand_payload();
            m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            r = $urandom_range(0, 9);
            if (r <= 5)      d = $urandom_range(1, 4);
            else if (r == 6) d = -1;
            else if (r == 7) d = TIMEOUT;
            else if (r == 8) d = 0;
            else             d = $urandom_range(5, TIMEOUT - 1);
            do_txn(m, d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", q_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
